fp_result_packer: RTL
=====================

Name: fp_result_packer

Overview:
Output stage placed directly after the four-stage floating-point add/subtract pipeline. It takes the pipeline's final exponent and 23-bit normalised mantissa, plus sign and exponent overflow/underflow indications. It packs each result into an IEEE-754 single-precision word with special-case handling and buffers results in a small FIFO with a valid/ready handshake. It also keeps saturating overflow and underflow event counters for status readout.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
COUNT_W, 16, width of each saturating event counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
clear  input  1  synchronous flush of the FIFO and both counters; takes priority over push and pop.
in_valid  input  1  upstream result present this cycle.
in_ready  output  1  block can accept; equals not-full.
in_sign  input  1  result sign.
in_exponent  input  8  biased exponent from the pipeline.
in_mantissa  input  23  fraction bits; hidden one already removed.
in_exp_ovf  input  1  exponent overflowed during normalisation.
in_exp_unf  input  1  exponent underflowed during normalisation.
out_valid  output  1  FIFO head holds a packed result.
out_ready  input  1  downstream accepts the head this cycle.
out_result  output  32  packed word {sign, exponent, fraction}.
out_ovf  output  1  overflow flag for the head entry.
out_unf  output  1  underflow flag for the head entry.
ovf_count  output  COUNT_W  number of accepted results flagged overflow; saturates.
unf_count  output  COUNT_W  number of accepted results flagged underflow; saturates.
level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst = 0), asynchronous:
  - FIFO empty, level = 0, out_valid = 0, in_ready = 1.
  - out_result = 0, out_ovf = 0, out_unf = 0.
  - ovf_count = 0, unf_count = 0.
- Packing is combinational on the inputs and is evaluated in priority order:
  1. in_exp_ovf = 1 or in_exponent = 8'hFF: word = {in_sign, 8'hFF, 23'h0} (infinity); ovf = 1, unf = 0.
  2. Otherwise, in_exp_unf = 1: word = {in_sign, 31'h0} (flush to zero); ovf = 0, unf = 1.
  3. Otherwise, in_exponent = 0: word = {in_sign, 31'h0}; ovf = 0; unf = 1 only if in_mantissa is non-zero. An exact zero is not flagged.
  4. Otherwise: word = {in_sign, in_exponent, in_mantissa}; both flags 0.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (level != DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - out_valid = (level != 0).
  - out_result, out_ovf and out_unf show the head entry. They are don't-care while out_valid = 0, but the bench checks that they hold the last value.
  - While out_valid = 1 and out_ready = 0, the head stays stable.
- Latency: an accepted input appears at the outputs in the next cycle at the earliest. There is no combinational bypass, even when the FIFO is empty.
- FIFO storage: DEPTH x 34 bits (word plus two flags). Read and write pointers are clog2(DEPTH) bits and wrap naturally.
- Boundary cases:
  - Full and pop: in_ready is low that cycle, so no push. in_ready rises the following cycle.
  - Empty and push: level becomes 1; out_valid rises the next cycle.
  - Push and pop in the same cycle, with 0 < level < DEPTH: level is unchanged and both pointers advance.
  - clear = 1: the next cycle has level = 0 and both counters = 0. Any push or pop in the clear cycle is discarded and does not count.
  - Reset mid-operation: all entries are lost and the outputs return to their reset values.
- Counters: on a push, ovf_count increments if the packed ovf = 1 and unf_count increments if the packed unf = 1. Each counter holds at 2^COUNT_W - 1 once it reaches it.

Decomposition:
- Shared package holds:
  - Field constants: EXP_W = 8, FRAC_W = 23, EXP_MAX = 8'hFF.
  - A packed-entry layout of 34 bits: {ovf, unf, word[31:0]}.
- One sub-module, fp_special_pack: purely combinational packing plus flag generation. It is unit-testable on its own.
- The FIFO and the counters stay in the top level.

Test Plan:
- Normal value: in_sign = 0, in_exponent = 8'h80, in_mantissa = 23'h400000, out_ready = 1 -> next cycle out_result = 32'h40400000, flags 0, ovf_count = 0.
- Overflow: in_exp_ovf = 1, in_sign = 1 -> out_result = 32'hFF800000, out_ovf = 1, ovf_count = 1. Then in_exponent = 8'hFF with no ovf input -> also 32'h7F800000 or 32'hFF800000 (by sign), ovf_count = 2.
- Zero versus underflow: in_exponent = 0, in_mantissa = 0 -> 32'h00000000 with unf = 0. in_exponent = 0, in_mantissa = 1 -> 32'h00000000 with unf = 1, unf_count = 1.
- Backpressure: out_ready = 0, push 5 values with DEPTH = 4 -> in_ready falls after the 4th push and level = 4. The 5th push is held. Then out_ready = 1 -> 4 words pop in order and the 5th is accepted once in_ready rises.
- Simultaneous push and pop at level = 2 for 10 cycles -> level stays 2 and output order matches input order across pointer wrap.
- Reset and clear: assert rst = 0 asynchronously while level = 3 -> outputs are zero before the next clock edge. Separately, clear = 1 while pushing -> level = 0, counters = 0 and the pushed value is discarded.

Source files
------------

// File: rtl/fp_result_packer_pkg.sv
// Shared field constants and the packed FIFO entry layout for the FP result
// packer. The entry is {ovf, unf, word[31:0]} = 34 bits.
package fp_result_packer_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              ovf;
    logic              unf;
    logic [WORD_W-1:0] word;
  } entry_t;

endpackage

// File: rtl/fp_special_pack.sv
// Combinational IEEE-754 single-precision packer with special-case handling.
//   sign, exponent, mantissa : pipeline result fields (hidden one removed)
//   exp_ovf, exp_unf         : normalisation overflow / underflow
//   entry                    : {ovf, unf, word}
// Priority: overflow/inf, forced underflow, zero/denormal flush, normal.
module fp_special_pack
  import fp_result_packer_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exponent,
  input  logic [FRAC_W-1:0] mantissa,
  input  logic              exp_ovf,
  input  logic              exp_unf,
  output entry_t            entry
);

  always_comb begin
    entry.ovf  = 1'b0;
    entry.unf  = 1'b0;
    entry.word = {sign, exponent, mantissa};
    if (exp_ovf || exponent == EXP_MAX) begin
      entry.ovf  = 1'b1;
      entry.word = {sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (exp_unf) begin
      entry.unf  = 1'b1;
      entry.word = {sign, {(WORD_W-1){1'b0}}};
    end else if (exponent == '0) begin
      // Denormals flush to signed zero; only a lost non-zero fraction counts
      // as underflow, an exact zero does not.
      entry.unf  = (mantissa != '0);
      entry.word = {sign, {(WORD_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_result_packer.sv
// Output stage after the FP add/sub pipeline: packs each result, buffers it in
// a DEPTH-entry FIFO (valid/ready both sides) and counts overflow/underflow
// events with saturating counters.
//   clk, rst (async, active low), clear (sync flush of FIFO + counters)
//   in_*      : upstream result + handshake (in_ready = not full)
//   out_*     : FIFO head + handshake
//   ovf_count, unf_count : saturating event counters
//   level     : FIFO occupancy
module fp_result_packer
  import fp_result_packer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_W-1:0]           in_exponent,
  input  logic [FRAC_W-1:0]          in_mantissa,
  input  logic                       in_exp_ovf,
  input  logic                       in_exp_unf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_result,
  output logic                       out_ovf,
  output logic                       out_unf,
  output logic [COUNT_W-1:0]         ovf_count,
  output logic [COUNT_W-1:0]         unf_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  entry_t             in_entry, head, last_q;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic [COUNT_W-1:0] ovf_q, unf_q;
  logic               push, pop;

  fp_special_pack u_pack (
    .sign     (in_sign),
    .exponent (in_exponent),
    .mantissa (in_mantissa),
    .exp_ovf  (in_exp_ovf),
    .exp_unf  (in_exp_unf),
    .entry    (in_entry)
  );

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // When empty the outputs keep showing the last entry popped (zero after
  // reset) instead of whatever stale slot rd_ptr now points at.
  assign head       = out_valid ? mem[rd_ptr] : last_q;
  assign out_result = head.word;
  assign out_ovf    = head.ovf;
  assign out_unf    = head.unf;
  assign level      = level_q;
  assign ovf_count  = ovf_q;
  assign unf_count  = unf_q;

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= head;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (push && in_entry.ovf && ovf_q != CNT_MAX) ovf_q <= ovf_q + COUNT_W'(1);
      if (push && in_entry.unf && unf_q != CNT_MAX) unf_q <= unf_q + COUNT_W'(1);
    end
  end

endmodule
